// File: rtl/sop_gate_array_if.sv
// sop_gate_array_if: valid/ready stream bundle for the AND-OR gate array.
// Master drives beats in and consumes results; slave is the array itself.
interface sop_gate_array_if #(
  parameter int CH    = 2,
  parameter int TERMS = 2,
  parameter int TW    = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [CH*TERMS*TW-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH-1:0]            out_y;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_y
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_y
  );
endinterface

// File: rtl/sop_gate_array.sv
// sop_gate_array: CH channels of masked AND-OR(-INVERT) logic.
// Two-stage valid/ready pipeline; config captured per beat at accept.
module sop_gate_array #(
  parameter int CH    = 2,
  parameter int TERMS = 2,
  parameter int TW    = 3
) (
  input  logic                clk,
  input  logic                areset_n,
  sop_gate_array_if.slave     bus,
  input  logic                cfg_we,
  input  logic [CH*TERMS-1:0] cfg_mask,
  input  logic [CH-1:0]       cfg_inv
);

  localparam int NT = CH * TERMS;

  logic [NT-1:0] mask_q;
  logic [CH-1:0] inv_q;

  logic          s1_valid;
  logic [NT-1:0] s1_terms;
  logic [CH-1:0] s1_inv;

  logic          s2_valid;
  logic [CH-1:0] s2_y;

  logic          s2_ready;
  logic          s1_adv;
  logic          in_ready;
  logic [NT-1:0] prod;
  logic [CH-1:0] y_d;

  assign s2_ready = !s2_valid || bus.out_ready;
  assign s1_adv   = s1_valid && s2_ready;
  assign in_ready = !s1_valid || s1_adv;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out_y     = s2_y;

  always_comb begin
    prod = '0;
    for (int i = 0; i < NT; i++) begin
      prod[i] = (&bus.in_data[i*TW +: TW]) & mask_q[i];
    end
  end

  always_comb begin
    y_d = '0;
    for (int c = 0; c < CH; c++) begin
      y_d[c] = (|s1_terms[c*TERMS +: TERMS]) ^ s1_inv[c];
    end
  end

  // A same-edge write must not reach the beat being accepted: the
  // beat samples mask_q/inv_q before this register updates.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      mask_q <= '1;
      inv_q  <= '0;
    end else if (cfg_we) begin
      mask_q <= cfg_mask;
      inv_q  <= cfg_inv;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      s1_valid <= 1'b0;
      s1_terms <= '0;
      s1_inv   <= '0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_terms <= prod;
        s1_inv   <= inv_q;
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y <= y_d;
      end
    end
  end

endmodule

// File: tb/tb_sop_gate_array.sv
// tb_sop_gate_array: directed and random stimulus for sop_gate_array.
// A queue model predicts ready/valid/data every cycle from the rules.
module tb_sop_gate_array;

  localparam int CH    = 2;
  localparam int TERMS = 2;
  localparam int TW    = 3;
  localparam int NT    = CH * TERMS;
  localparam int DW    = NT * TW;

  logic          clk = 1'b0;
  logic          areset_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [NT-1:0] cfg_mask = '0;
  logic [CH-1:0] cfg_inv = '0;

  logic          drv_has_lit = 1'b0;
  logic [CH-1:0] drv_lit = '0;
  logic          final_chk = 1'b0;
  logic          done = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int accepted = 0;

  sop_gate_array_if #(.CH(CH), .TERMS(TERMS), .TW(TW)) bus ();

  sop_gate_array #(.CH(CH), .TERMS(TERMS), .TW(TW)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus),
    .cfg_we   (cfg_we),
    .cfg_mask (cfg_mask),
    .cfg_inv  (cfg_inv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] y;
    int            cyc;
    bit            has_lit;
    logic [CH-1:0] lit;
  } ent_t;

  ent_t          q[$];
  logic [NT-1:0] mask_m = '1;
  logic [CH-1:0] inv_m = '0;

  function automatic logic [CH-1:0] model(
    input logic [DW-1:0] d,
    input logic [NT-1:0] m,
    input logic [CH-1:0] inv
  );
    logic [CH-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      bit any;
      any = 0;
      for (int t = 0; t < TERMS; t++) begin
        int  idx;
        bit  all1;
        idx  = c * TERMS + t;
        all1 = 1;
        for (int b = 0; b < TW; b++)
          if (d[idx*TW + b] !== 1'b1) all1 = 0;
        if (m[idx] && all1) any = 1;
      end
      r[c] = any ^ inv[c];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Single checker process: all comparisons happen here.
  always @(negedge clk or negedge areset_n) begin
    if (!areset_n) begin
      #1;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_y", {{(32-CH){1'b0}}, bus.out_y}, 32'd0);
      q.delete();
      mask_m = '1;
      inv_m  = '0;
    end else begin
      ent_t e;
      bit   exp_rdy;
      bit   exp_ov;
      cyc++;
      exp_rdy = (q.size() < 2) || bus.out_ready;
      exp_ov  = (q.size() > 0) && (q[0].cyc <= cyc - 2);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
      if (bus.out_valid && q.size() > 0) begin
        chk("out_y", {{(32-CH){1'b0}}, bus.out_y},
            {{(32-CH){1'b0}}, q[0].y});
        if (q[0].has_lit)
          chk("out_y_literal", {{(32-CH){1'b0}}, bus.out_y},
              {{(32-CH){1'b0}}, q[0].lit});
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        e.y       = model(bus.in_data, mask_m, inv_m);
        e.cyc     = cyc;
        e.has_lit = drv_has_lit;
        e.lit     = drv_lit;
        q.push_back(e);
        accepted++;
      end
      if (cfg_we) begin
        mask_m = cfg_mask;
        inv_m  = cfg_inv;
      end
      if (final_chk && !done) begin
        chk("drain_empty", q.size(), 32'd0);
        done = 1'b1;
      end
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic wait_acc();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL accept_timeout: in_ready stuck low");
      $fatal(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit hl,
                      input logic [CH-1:0] lit);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    drv_has_lit  = hl;
    drv_lit      = lit;
    wait_acc();
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    drv_has_lit  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_w(input logic [NT-1:0] m, input logic [CH-1:0] i);
    cfg_we   = 1'b1;
    cfg_mask = m;
    cfg_inv  = i;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    drv_has_lit   = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      $display("FAIL drain_timeout: %0d beats stuck", q.size());
      $fatal(1);
    end
    idle(2);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 areset_n = 1'b1;
    @(posedge clk);
    #1;

    // Default config literals, back to back
    send(12'h007, 1, 2'b01);
    send(12'hE00, 1, 2'b10);
    send(12'h1B6, 1, 2'b00);
    drain();

    // Mask out term 0 of channel 0
    cfg_w(4'b1110, 2'b00);
    send(12'h007, 1, 2'b00);
    send(12'h038, 1, 2'b01);
    drain();

    // AND-OR-INVERT on channel 1
    cfg_w(4'b1111, 2'b10);
    send(12'h000, 1, 2'b10);
    send(12'hFFF, 1, 2'b01);
    drain();

    // Backpressure: A, B held, C stalls
    bus.out_ready = 1'b0;
    send(12'h007, 1, 2'b11);
    send(12'hE00, 1, 2'b00);
    bus.in_data = 12'hFFF;
    drv_lit     = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_acc();
    drain();

    // Config write at the same edge as an accept
    cfg_w(4'b1111, 2'b00);
    cfg_we       = 1'b1;
    cfg_mask     = 4'b1111;
    cfg_inv      = 2'b11;
    bus.in_valid = 1'b1;
    bus.in_data  = 12'h007;
    drv_has_lit  = 1'b1;
    drv_lit      = 2'b01;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    send(12'h007, 1, 2'b10);
    drain();

    // Async reset with two beats in flight
    cfg_w(4'b0000, 2'b11);
    bus.out_ready = 1'b0;
    send(12'h007, 0, 2'b00);
    send(12'hE00, 0, 2'b00);
    idle(0);
    #1 areset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 areset_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    idle(4);
    send(12'h007, 1, 2'b01);
    send(12'hE00, 1, 2'b10);
    drain();

    // Random beats, random backpressure and config writes
    begin
      int base;
      base = accepted;
      for (int i = 0; i < 20000 && accepted < base + 400; i++) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.in_data   = DW'($urandom);
        bus.out_ready = ($urandom_range(0, 2) != 0);
        cfg_we        = ($urandom_range(0, 15) == 0);
        cfg_mask      = NT'($urandom);
        cfg_inv       = CH'($urandom);
        drv_has_lit   = 1'b0;
        @(posedge clk);
        #1;
      end
      cfg_we = 1'b0;
      if (accepted < base + 400) begin
        $display("FAIL random_timeout: %0d beats accepted",
                 accepted - base);
        $fatal(1);
      end
    end
    drain();

    final_chk = 1'b1;
    for (int i = 0; i < 10 && !done; i++) @(posedge clk);
    if (!done) begin
      $display("FAIL final_timeout: checker idle");
      $fatal(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sop_gate_array.md
SOP_GATE_ARRAY -- requirements
Module: sop_gate_array

Interface
REQ-001 The block SHALL have the parameter CH, default 2, meaning the number of independent AND-OR channels (legal range 1..16).
REQ-002 The block SHALL have the parameter TERMS, default 2, meaning the number of product terms per channel (legal range 1..8).
REQ-003 The block SHALL have the parameter TW, default 3, meaning the number of inputs per product term (legal range 1..8).
REQ-004 The block SHALL have these ports:
- clk  in  1  clock; all state updates on the rising edge.
- areset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  the input beat is valid.
- in_ready  out  1  the block can accept a beat.
- in_data  in  CH*TERMS*TW  term inputs; term t of channel c is in_data[(c*TERMS+t)*TW +: TW].
- out_valid  out  1  out_y is valid.
- out_ready  in  1  the consumer accepts out_y.
- out_y  out  CH  per-channel result.
- cfg_we  in  1  write enable for the configuration registers.
- cfg_mask  in  CH*TERMS  term enables; bit c*TERMS+t enables term t of channel c.
- cfg_inv  in  CH  per-channel output inversion (AND-OR-INVERT mode).
REQ-005 Reset SHALL be asynchronous and active-low on areset_n, with the single clock clk.

Function
REQ-006 Product term SHALL be the AND of its TW bits, forced to 0 when its mask bit is 0.
REQ-007 Channel result SHALL be the OR of its TERMS product terms, XORed with its cfg_inv bit; all terms masked gives 0 before inversion.
REQ-008 Pipeline SHALL have two register stages (S1: masked product terms plus the inv bits; S2: out_y), each with its own valid flag.
REQ-009 A beat SHALL be accepted when in_valid and in_ready are both 1 at a rising clk edge.
REQ-010 A beat SHALL be consumed when out_valid and out_ready are both 1 at a rising clk edge.
REQ-011 S2 SHALL load when S1 is valid and (S2 is empty or S2 is consumed in the same cycle).
REQ-012 in_ready SHALL equal (not S1 valid) or (S1 advances into S2 this cycle); it is combinational from out_ready and holds no other path from in_valid.
REQ-013 Latency: a beat accepted at edge N SHALL present out_valid=1 and its out_y after edge N+2 when out_ready stays 1.
REQ-014 Throughput SHALL be one beat per cycle with no bubbles while out_ready=1.
REQ-015 Under backpressure (out_ready=0) the block SHALL hold at most 2 beats, then deassert in_ready; out_y SHALL stay stable while out_valid=1 and out_ready=0.
REQ-016 Beats SHALL never be dropped, duplicated or reordered.
REQ-017 cfg_we=1 SHALL update the mask and inv registers at the rising clk edge.
REQ-018 A beat SHALL use the configuration register values present when it is accepted into S1; a beat accepted at the same edge as a cfg_we write uses the old values.
REQ-019 Beats already in S1 or S2 SHALL be unaffected by later configuration writes.
REQ-020 S1 and S2 contents SHALL not change while their stage is stalled.

Reset
REQ-021 While areset_n=0, independent of clk, the block SHALL drive out_valid=0, out_y=0 and clear both stage valid flags.
REQ-022 Reset SHALL set the mask register to all ones and the inv register to all zeros.
REQ-023 in_ready SHALL be 1 from the first edge after release of areset_n.
REQ-024 A reset asserted mid-operation SHALL discard in-flight beats; no partial beat SHALL appear after release.

Verification (CH=2, TERMS=2, TW=3)
REQ-025 A bench SHALL apply in_data=12'h007 with default config and out_ready=1 -> out_y=2'b01 with out_valid=1 exactly 2 cycles after accept; 12'hE00 -> 2'b10; 12'h1B6 -> 2'b00.
REQ-026 A bench SHALL write cfg_mask=4'b1110, then apply 12'h007 -> out_y=2'b00; then 12'h038 -> out_y=2'b01.
REQ-027 A bench SHALL write cfg_inv=2'b10, then apply 12'h000 -> out_y=2'b10; then 12'hFFF -> out_y=2'b01.
REQ-028 A bench SHALL hold out_ready=0 and offer 3 beats (A, B, C) back-to-back -> in_ready=0 after A and B are held, C stalls; after out_ready=1, the outputs are A, B, C in order with out_y stable during the stall.
REQ-029 A bench SHALL write cfg_we at the same edge a beat is accepted -> that beat uses the old config and the next beat uses the new config.
REQ-030 A bench SHALL assert areset_n=0 asynchronously with 2 beats in flight -> out_valid=0 and out_y=0 immediately, mask=all ones and inv=0 after release, and no stale beat emerges.
REQ-031 A bench SHALL apply 400 random beats with random out_ready against a scoreboard -> zero mismatches.
